// File: rtl/branch_history_tracker_if.sv
// rtl/branch_history_tracker_if.sv - predictor-side bus of the speculative branch history tracker
interface branch_history_tracker_if #(
  parameter int HIST_LEN = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 31
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                IN_predValid;
  logic [ADDR_W-1:0]   IN_predAddr;
  logic                IN_predTaken;
  logic [2:0]          IN_predTageID;
  logic [2:0]          IN_predUseful;
  logic                OUT_predReady;
  logic [IDX_W-1:0]    OUT_predIdx;
  logic [HIST_LEN-1:0] OUT_history;
  logic                IN_resValid;
  logic                IN_resTaken;
  logic                IN_flush;
  logic                OUT_mispredict;
  logic                OUT_writeValid;
  logic [ADDR_W-1:0]   OUT_writeAddr;
  logic [HIST_LEN-1:0] OUT_writeHistory;
  logic [2:0]          OUT_writeTageID;
  logic                OUT_writeTaken;
  logic [2:0]          OUT_writeUseful;
  logic                OUT_writePred;

  // pipeline / predictor side
  modport master (
    output IN_predValid, IN_predAddr, IN_predTaken, IN_predTageID, IN_predUseful,
    output IN_resValid, IN_resTaken, IN_flush,
    input  OUT_predReady, OUT_predIdx, OUT_history, OUT_mispredict,
    input  OUT_writeValid, OUT_writeAddr, OUT_writeHistory, OUT_writeTageID,
    input  OUT_writeTaken, OUT_writeUseful, OUT_writePred
  );

  // tracker side
  modport slave (
    input  IN_predValid, IN_predAddr, IN_predTaken, IN_predTageID, IN_predUseful,
    input  IN_resValid, IN_resTaken, IN_flush,
    output OUT_predReady, OUT_predIdx, OUT_history, OUT_mispredict,
    output OUT_writeValid, OUT_writeAddr, OUT_writeHistory, OUT_writeTageID,
    output OUT_writeTaken, OUT_writeUseful, OUT_writePred
  );
endinterface

// File: rtl/branch_history_tracker.sv
// rtl/branch_history_tracker.sv - speculative global history with per-branch checkpoints; BHT_PATH_HIST_EN mixes addr[1] into history
module branch_history_tracker #(
  parameter int HIST_LEN = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  branch_history_tracker_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

`ifdef BHT_PATH_HIST_EN
  localparam logic PATH_EN = 1'b1;
`else
  localparam logic PATH_EN = 1'b0;
`endif

  typedef struct packed {
    logic [HIST_LEN-1:0] hist;
    logic [ADDR_W-1:0]   addr;
    logic [2:0]          tage_id;
    logic [2:0]          useful;
    logic                pred;
  } entry_t;

  entry_t              slots_q [DEPTH];
  logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [HIST_LEN-1:0] spec_hist_q, spec_hist_d, comm_hist_q, comm_hist_d;
  entry_t              wr_entry_q;
  logic                wr_valid_q, wr_taken_q, mispredict_q;

  entry_t              head_e;
  logic                ready, res_go, mispred, acc_go;
  logic [HIST_LEN-1:0] res_hist;

  // Event decode: flush beats mispredict beats accept; next-state for pointers and histories
  always_comb begin
    head_e      = slots_q[head_q];
    ready       = (count_q != CNT_W'(DEPTH));
    res_go      = bus.IN_resValid && (count_q != '0) && !bus.IN_flush;
    mispred     = res_go && (bus.IN_resTaken != head_e.pred);
    acc_go      = bus.IN_predValid && ready && !bus.IN_flush && !mispred;
    res_hist    = {head_e.hist[HIST_LEN-2:0], bus.IN_resTaken ^ (PATH_EN & head_e.addr[1])};
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    spec_hist_d = spec_hist_q;
    comm_hist_d = comm_hist_q;
    if (bus.IN_flush) begin
      spec_hist_d = comm_hist_q;
      head_d      = tail_q;
      count_d     = '0;
    end else begin
      if (res_go) begin
        head_d      = head_q + IDX_W'(1);
        comm_hist_d = res_hist;
      end
      if (mispred) begin
        // repair from the resolved checkpoint; everything younger is gone
        spec_hist_d = res_hist;
        tail_d      = head_q + IDX_W'(1);
        count_d     = '0;
      end else begin
        if (acc_go) begin
          spec_hist_d = {spec_hist_q[HIST_LEN-2:0],
                         bus.IN_predTaken ^ (PATH_EN & bus.IN_predAddr[1])};
          tail_d      = tail_q + IDX_W'(1);
        end
        count_d = count_q + CNT_W'(acc_go) - CNT_W'(res_go);
      end
    end
  end

  // Checkpoint storage: capture pre-shift history and predictor metadata at the tail
  always_ff @(posedge clk) begin
    if (acc_go) begin
      slots_q[tail_q] <= '{hist:    spec_hist_q,
                           addr:    bus.IN_predAddr,
                           tage_id: bus.IN_predTageID,
                           useful:  bus.IN_predUseful,
                           pred:    bus.IN_predTaken};
    end
  end

  // Pointer, count and history registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      spec_hist_q <= '0;
      comm_hist_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      spec_hist_q <= spec_hist_d;
      comm_hist_q <= comm_hist_d;
    end
  end

  // Training port: pulse on each accepted resolve, payload holds between pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_valid_q   <= 1'b0;
      mispredict_q <= 1'b0;
      wr_taken_q   <= 1'b0;
      wr_entry_q   <= '0;
    end else begin
      wr_valid_q   <= res_go;
      mispredict_q <= mispred;
      if (res_go) begin
        wr_entry_q <= head_e;
        wr_taken_q <= bus.IN_resTaken;
      end
    end
  end

  assign bus.OUT_predReady    = ready;
  assign bus.OUT_predIdx      = tail_q;
  assign bus.OUT_history      = spec_hist_q;
  assign bus.OUT_mispredict   = mispredict_q;
  assign bus.OUT_writeValid   = wr_valid_q;
  assign bus.OUT_writeAddr    = wr_entry_q.addr;
  assign bus.OUT_writeHistory = wr_entry_q.hist;
  assign bus.OUT_writeTageID  = wr_entry_q.tage_id;
  assign bus.OUT_writeTaken   = wr_taken_q;
  assign bus.OUT_writeUseful  = wr_entry_q.useful;
  assign bus.OUT_writePred    = wr_entry_q.pred;
endmodule

// File: tb/tb_branch_history_tracker.sv
// tb/tb_branch_history_tracker.sv - scoreboard bench for branch_history_tracker
module tb_branch_history_tracker;
  localparam int HL = 16;
  localparam int D  = 8;
  localparam int AW = 31;
`ifdef BHT_PATH_HIST_EN
  localparam logic PATH = 1'b1;
`else
  localparam logic PATH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_history_tracker_if #(.HIST_LEN(HL), .DEPTH(D), .ADDR_W(AW)) bus ();

  branch_history_tracker #(.HIST_LEN(HL), .DEPTH(D), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [HL-1:0] hist;
    logic [AW-1:0] addr;
    logic [2:0]    tid;
    logic [2:0]    use_v;
    logic          pred;
  } ent_t;

  typedef struct {
    ent_t e;
    logic taken;
    logic mis;
  } wr_t;

  ent_t          mq[$];
  wr_t           sb[$];
  logic [HL-1:0] m_spec, m_comm;
  int            m_tail;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [HL-1:0] shl(input logic [HL-1:0] h, input logic dir, input logic a1);
    return {h[HL-2:0], dir ^ (PATH & a1)};
  endfunction

  task automatic idle();
    bus.IN_predValid  = 1'b0;
    bus.IN_predAddr   = '0;
    bus.IN_predTaken  = 1'b0;
    bus.IN_predTageID = '0;
    bus.IN_predUseful = '0;
    bus.IN_resValid   = 1'b0;
    bus.IN_resTaken   = 1'b0;
    bus.IN_flush      = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_history", bus.OUT_history, 0);
    chk("rst_idx", bus.OUT_predIdx, 0);
    chk("rst_ready", bus.OUT_predReady, 1);
    chk("rst_wvalid", bus.OUT_writeValid, 0);
    chk("rst_mispredict", bus.OUT_mispredict, 0);
    chk("rst_whist", bus.OUT_writeHistory, 0);
    chk("rst_waddr", bus.OUT_writeAddr, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mq.delete();
    sb.delete();
    m_spec = '0;
    m_comm = '0;
    m_tail = 0;
  endtask

  // one clock: check pre-edge state, drive, advance model, then score the registered outputs
  task automatic cyc(input logic pv, input logic [AW-1:0] addr, input logic pt,
                     input logic [2:0] tid, input logic [2:0] use_v,
                     input logic rv, input logic rt, input logic fl);
    logic ready_m, res_go, mis, acc;
    ent_t e;
    wr_t  w;
    e = '{default: '0};
    ready_m = (mq.size() != D);
    chk("ready", bus.OUT_predReady, ready_m);
    chk("idx", bus.OUT_predIdx, m_tail);
    chk("history", bus.OUT_history, m_spec);
    bus.IN_predValid  = pv;
    bus.IN_predAddr   = addr;
    bus.IN_predTaken  = pt;
    bus.IN_predTageID = tid;
    bus.IN_predUseful = use_v;
    bus.IN_resValid   = rv;
    bus.IN_resTaken   = rt;
    bus.IN_flush      = fl;
    res_go = rv && (mq.size() > 0) && !fl;
    mis    = 1'b0;
    if (res_go) begin
      e   = mq[0];
      mis = (rt != e.pred);
    end
    acc = pv && ready_m && !fl && !mis;
    if (fl) begin
      m_spec = m_comm;
      mq.delete();
    end else begin
      if (res_go) begin
        void'(mq.pop_front());
        m_comm = shl(e.hist, rt, e.addr[1]);
        sb.push_back('{e: e, taken: rt, mis: mis});
      end
      if (mis) begin
        m_spec = m_comm;
        m_tail = (m_tail - mq.size() + D) % D;
        mq.delete();
      end else if (acc) begin
        mq.push_back('{hist: m_spec, addr: addr, tid: tid, use_v: use_v, pred: pt});
        m_spec = shl(m_spec, pt, addr[1]);
        m_tail = (m_tail + 1) % D;
      end
    end
    @(posedge clk); #1;
    idle();
    if (sb.size() > 0) begin
      w = sb.pop_front();
      chk("wr_valid", bus.OUT_writeValid, 1);
      chk("wr_addr", bus.OUT_writeAddr, w.e.addr);
      chk("wr_hist", bus.OUT_writeHistory, w.e.hist);
      chk("wr_tid", bus.OUT_writeTageID, w.e.tid);
      chk("wr_useful", bus.OUT_writeUseful, w.e.use_v);
      chk("wr_pred", bus.OUT_writePred, w.e.pred);
      chk("wr_taken", bus.OUT_writeTaken, w.taken);
      chk("mispredict", bus.OUT_mispredict, w.mis);
    end else begin
      chk("wr_valid", bus.OUT_writeValid, 0);
      chk("mispredict", bus.OUT_mispredict, 0);
    end
  endtask

  task automatic pred(input logic [AW-1:0] addr, input logic pt);
    cyc(1'b1, addr, pt, 3'(addr[2:0] + 1), 3'(addr[4:2]), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic rt);
    cyc(1'b0, '0, 1'b0, 3'd0, 3'd0, 1'b1, rt, 1'b0);
  endtask

  initial begin
    idle();
    do_reset();

    // three predictions, then in-order resolve of the oldest
    pred(31'h100, 1'b1);
    pred(31'h104, 1'b0);
    pred(31'h108, 1'b1);
`ifndef BHT_PATH_HIST_EN
    chk("tp1_hist", bus.OUT_history, 16'h0005);
    chk("tp1_idx", bus.OUT_predIdx, 3);
`endif
    resolve(1'b1);
    chk("tp2_whist", bus.OUT_writeHistory, 16'h0000);
    chk("tp2_wtaken", bus.OUT_writeTaken, 1);
    chk("tp2_wpred", bus.OUT_writePred, 1);
    chk("tp2_mis", bus.OUT_mispredict, 0);
    resolve(1'b1);
    resolve(1'b1);
    resolve(1'b1);

    // mispredict with a colliding prediction
    do_reset();
    for (int i = 0; i < 4; i++) pred(31'h200 + 31'(4 * i), 1'b1);
    cyc(1'b1, 31'h300, 1'b1, 3'd2, 3'd5, 1'b1, 1'b0, 1'b0);
    chk("tp3_mis", bus.OUT_mispredict, 1);
`ifndef BHT_PATH_HIST_EN
    chk("tp3_hist", bus.OUT_history, 16'h0000);
`endif
    chk("tp3_idx", bus.OUT_predIdx, 1);
    resolve(1'b0);

    // full queue, no bypass on simultaneous resolve
    do_reset();
    for (int i = 0; i < D; i++) pred(31'h400 + 31'(4 * i), 1'b1);
    chk("tp4_full", bus.OUT_predReady, 0);
    pred(31'h500, 1'b0);
`ifndef BHT_PATH_HIST_EN
    chk("tp4_hist", bus.OUT_history, 16'h00FF);
`endif
    cyc(1'b1, 31'h504, 1'b0, 3'd1, 3'd1, 1'b1, 1'b1, 1'b0);
    chk("tp4_ready", bus.OUT_predReady, 1);

    // commit two, then flush back to committed history
    do_reset();
    pred(31'h600, 1'b1);
    pred(31'h604, 1'b1);
    resolve(1'b1);
    resolve(1'b1);
    pred(31'h608, 1'b0);
    pred(31'h60C, 1'b0);
    cyc(1'b1, 31'h610, 1'b1, 3'd3, 3'd3, 1'b1, 1'b0, 1'b1);
`ifndef BHT_PATH_HIST_EN
    chk("tp5_hist", bus.OUT_history, 16'h0003);
`endif
    chk("tp5_wvalid", bus.OUT_writeValid, 0);
    resolve(1'b1);

`ifdef BHT_PATH_HIST_EN
    do_reset();
    pred(31'h2, 1'b1);
    chk("tp6_path_hist0", bus.OUT_history, 16'h0000);
    do_reset();
    pred(31'h0, 1'b1);
    chk("tp6_path_hist1", bus.OUT_history, 16'h0001);
`endif

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 31'($urandom), 1'($urandom),
          3'($urandom), 3'($urandom), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 30) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_history_tracker.md
Name: branch_history_tracker

Overview:
- Speculative global-history manager that sits directly upstream of the TAGE predictor.
- Supplies the 16-bit branch history used for prediction lookups.
- Keeps one checkpoint per in-flight predicted branch in a circular FIFO.
- Drives the predictor's write/training port in order as branches resolve.
- On a mispredict, repairs the history from the checkpoint and flushes younger branches.

Parameters:
- HIST_LEN, 16, width of the global history (matches predictor history input).
- DEPTH, 8, number of in-flight branch checkpoints; must be a power of 2, at least 2.
- ADDR_W, 31, branch address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- IN_predValid  in  1  a predicted branch is presented this cycle.
- IN_predAddr  in  ADDR_W  branch address.
- IN_predTaken  in  1  predicted direction.
- IN_predTageID  in  3  providing stage ID from the predictor.
- IN_predUseful  in  3  per-stage prediction vector from the predictor.
- OUT_predReady  out  1  a checkpoint slot is free; combinational, equals count != DEPTH.
- OUT_predIdx  out  log2(DEPTH)  slot index the next accepted branch will occupy (tail pointer).
- OUT_history  out  HIST_LEN  current speculative history, feeds predictor lookup.
- IN_resValid  in  1  the oldest in-flight branch resolves this cycle.
- IN_resTaken  in  1  actual direction of the oldest branch.
- IN_flush  in  1  pipeline flush; discard all in-flight branches.
- OUT_mispredict  out  1  registered one-cycle pulse when a resolve mismatched the prediction.
- OUT_writeValid  out  1  registered one-cycle training pulse.
- OUT_writeAddr  out  ADDR_W  training: branch address.
- OUT_writeHistory  out  HIST_LEN  training: history as it was at prediction time.
- OUT_writeTageID  out  3  training: stored providing stage ID.
- OUT_writeTaken  out  1  training: actual direction.
- OUT_writeUseful  out  3  training: stored per-stage vector.
- OUT_writePred  out  1  training: stored predicted direction.

Behaviour:
- Reset (async, rst=0):
  - specHist and commitHist cleared to 0.
  - head, tail and count cleared to 0.
  - All OUT_write* outputs, OUT_mispredict and OUT_writeValid are 0.
  - OUT_history reads 0.
- Shift rule: hist' = {hist[HIST_LEN-2:0], b}. The bit b is the direction bit.
- Accept:
  - A prediction is accepted when IN_predValid & OUT_predReady and no higher-priority event is active.
  - The slot at tail stores: specHist before the shift, addr, TageID, Useful, predTaken.
  - specHist then shifts in predTaken. tail increments with wrap modulo DEPTH; count increments.
  - OUT_history is the register value, so it changes in the cycle after acceptance.
- Resolve:
  - Acts on the head entry only (in-order resolve).
  - IN_resValid with count==0 is ignored entirely: no write pulse.
  - On a valid resolve, next cycle OUT_writeValid=1. The stored fields are driven out, with OUT_writeTaken = IN_resTaken.
  - head increments and count decrements. commitHist = shift(entry.hist, resTaken).
- Mispredict (resTaken != entry.predTaken):
  - Everything in the correct-resolve case still happens.
  - specHist = shift(entry.hist, resTaken).
  - tail = head+1, so all younger entries are discarded; count becomes 0.
  - OUT_mispredict pulses in the next cycle.
  - A prediction presented in the same cycle is dropped and not allocated.
- Correct resolve with a simultaneous accept: both take effect; count is unchanged net.
- Full: OUT_predReady is 0 when count==DEPTH, even if a resolve arrives that cycle (no bypass). A prediction presented while ready=0 is ignored.
- Flush:
  - IN_flush has highest priority. specHist = commitHist; head = tail; count = 0.
  - A resolve in the same cycle is dropped; no write pulse.
  - A prediction in the same cycle is dropped.
- Priority order: flush > mispredict > accept.
- The write outputs hold their last values while OUT_writeValid=0.

Optional Feature:
- Macro: BHT_PATH_HIST_EN.
- When defined:
  - Shifted-in bit b = direction XOR addr[1]. On accept this uses IN_predAddr[1]; on resolve and repair it uses the stored addr[1].
  - This yields mixed path/direction history.
- When undefined: b = direction only.
- The checkpoint contents and the training port are identical in both builds.

Test Plan:
- Reset, then accept 3 branches with taken=1,0,1 -> OUT_history=16'h0005; OUT_predIdx=3; count=3.
- Resolve the oldest of the previous 3 with resTaken=1 -> next cycle OUT_writeValid=1, OUT_writeHistory=16'h0000, OUT_writeTaken=1, OUT_writePred=1. OUT_mispredict=0.
- Accept 4 branches with predicted taken=1 from history 0. Resolve the oldest with resTaken=0, and present a new prediction in the same cycle -> OUT_history=16'h0000, count=0, OUT_mispredict pulses, the new prediction is not allocated.
- Fill 8 entries -> OUT_predReady=0. A 9th prediction is ignored and OUT_history is unchanged. Resolve once -> ready=1 the cycle after.
- Commit 2 branches taken=1,1 -> commitHist=16'h0003. Accept 2 more, then assert IN_flush -> OUT_history=16'h0003, count=0, no OUT_writeValid.
- With BHT_PATH_HIST_EN defined, accept from history 0 with taken=1 and IN_predAddr=31'h2 -> OUT_history=16'h0000. Repeat with addr=31'h0 -> OUT_history=16'h0001.
